// File: rtl/cfa_window_mac.sv
// cfa_window_mac: weighted sum over the upstream 1D shift-buffer window.
// Each tap is multiplied by a programmable signed coefficient and the products
// are summed. The sum is scaled by 2^-FracBits and clipped to one signed
// DataBitWidth pixel. An internal fill counter suppresses output until the
// window holds real samples. Pipeline: E0 qualify, E1 multiply, E2 sum,
// E3 scale/clip/output.
//
// Optional feature: define CFA_MAC_ROUND_EN to round half toward +inf before
// the scaling shift. Without it the scaling is a plain arithmetic shift (floor).
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   en, shift    same qualifiers as driven to the upstream buffer
//   win_in       flattened window, tap k at [k*DataBitWidth +: DataBitWidth],
//                tap BufferSize-1 newest
//   coeff_in     signed coefficients, same packing as win_in
//   coeff_load   capture coeff_in into the coefficient bank
//   d_out        signed filtered pixel
//   d_valid      one-cycle strobe per accepted full window
//   sat          d_out was clipped (qualified by d_valid)
module cfa_window_mac #(
  parameter int unsigned DataBitWidth  = 12,
  parameter int unsigned BufferSize    = 5,
  parameter int unsigned CoeffBitWidth = 8,
  parameter int unsigned FracBits      = 6
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic                                    shift,
  input  logic [BufferSize*DataBitWidth-1:0]      win_in,
  input  logic [BufferSize*CoeffBitWidth-1:0]     coeff_in,
  input  logic                                    coeff_load,
  output logic signed [DataBitWidth-1:0]          d_out,
  output logic                                    d_valid,
  output logic                                    sat
);

  localparam int unsigned D      = DataBitWidth;
  localparam int unsigned N      = BufferSize;
  localparam int unsigned C      = CoeffBitWidth;
  localparam int unsigned F      = FracBits;
  localparam int unsigned ProdW  = D + C;
  localparam int unsigned SumW   = D + C + $clog2(N);
  localparam int unsigned CntW   = $clog2(N + 1);
  localparam int unsigned Center = N / 2;

`ifdef CFA_MAC_ROUND_EN
  localparam int unsigned ScW = SumW + 1;
`else
  localparam int unsigned ScW = SumW;
`endif

  localparam logic signed [C-1:0]   Unity = C'(1 << F);
  localparam logic signed [ScW-1:0] MaxV  = {{(ScW-D+1){1'b0}}, {(D-1){1'b1}}};
  localparam logic signed [ScW-1:0] MinV  = {{(ScW-D+1){1'b1}}, {(D-1){1'b0}}};

  logic                    shift_ev_c;
  logic [CntW-1:0]         fill_cnt;
  logic [CntW-1:0]         fill_nxt_c;
  logic                    shift_d;
  logic                    full_d;
  logic                    v1;
  logic                    v2;
  logic signed [C-1:0]     coef [N];
  logic signed [ProdW-1:0] prod [N];
  logic signed [SumW-1:0]  sum;
  logic signed [SumW-1:0]  sum_c;
  logic signed [ScW-1:0]   scaled_c;
  logic signed [D-1:0]     clip_c;
  logic                    sat_c;

  // Shift event and the fill count it produces.
  always_comb begin
    shift_ev_c = en && shift;
    fill_nxt_c = fill_cnt;
    if (shift_ev_c && (fill_cnt != CntW'(N))) begin
      fill_nxt_c = fill_cnt + CntW'(1);
    end
  end

  // Coefficient bank; resets to a pass-through of the centre tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) begin
        coef[k] <= (k == Center) ? Unity : '0;
      end
    end else if (coeff_load) begin
      for (int unsigned k = 0; k < N; k++) begin
        coef[k] <= coeff_in[k*C +: C];
      end
    end
  end

  // Stage 0: fill tracking and shift qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
      shift_d  <= 1'b0;
      full_d   <= 1'b0;
    end else begin
      fill_cnt <= fill_nxt_c;
      shift_d  <= shift_ev_c;
      full_d   <= (fill_nxt_c == CntW'(N));
    end
  end

  // Stage 1: per-tap products; the window settled at the previous edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        prod[k] <= '0;
      end
    end else begin
      v1 <= shift_d && full_d;
      if (shift_d) begin
        for (int unsigned k = 0; k < N; k++) begin
          prod[k] <= ProdW'($signed(win_in[k*D +: D])) * ProdW'(coef[k]);
        end
      end
    end
  end

  // Full-precision adder tree; SumW leaves headroom for N products.
  always_comb begin
    sum_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum_c = sum_c + SumW'(prod[k]);
    end
  end

  // Stage 2: register the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      v2  <= 1'b0;
    end else begin
      sum <= sum_c;
      v2  <= v1;
    end
  end

  // Scale by 2^-F (optionally rounded half toward +inf).
`ifdef CFA_MAC_ROUND_EN
  localparam logic signed [ScW-1:0] Half = ScW'(1) << (F - 1);
  logic signed [ScW-1:0] rnd_c;
  always_comb begin
    rnd_c    = ScW'(sum) + Half;
    scaled_c = rnd_c >>> F;
  end
`else
  always_comb begin
    scaled_c = sum >>> F;
  end
`endif

  // Clip to one signed pixel.
  always_comb begin
    clip_c = scaled_c[D-1:0];
    sat_c  = 1'b0;
    if (scaled_c > MaxV) begin
      clip_c = MaxV[D-1:0];
      sat_c  = 1'b1;
    end else if (scaled_c < MinV) begin
      clip_c = MinV[D-1:0];
      sat_c  = 1'b1;
    end
  end

  // Stage 3: output; data holds through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out   <= '0;
      sat     <= 1'b0;
      d_valid <= 1'b0;
    end else begin
      d_valid <= v2;
      if (v2) begin
        d_out <= clip_c;
        sat   <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_cfa_window_mac.sv
// Testbench for cfa_window_mac: models the upstream shift buffer, issues
// directed windows with hand-computed expected pixels into a scoreboard, and
// a negedge monitor pops and compares whenever d_valid is seen.
module tb_cfa_window_mac;

  localparam int unsigned D = 12;
  localparam int unsigned N = 5;
  localparam int unsigned C = 8;

`ifdef CFA_MAC_ROUND_EN
  localparam int RndPos = 2;
  localparam int RndNeg = -1;
`else
  localparam int RndPos = 1;
  localparam int RndNeg = -2;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   en = 1'b0;
  logic                   shift = 1'b0;
  logic                   coeff_load = 1'b0;
  logic [N*D-1:0]         win;
  logic [N*C-1:0]         coeff_in = '0;
  logic signed [D-1:0]    d_out;
  logic                   d_valid;
  logic                   sat;

  int                     sample = 0;
  int                     checks = 0;
  int                     errors = 0;
  int                     exp_d[$];
  bit                     exp_s[$];
  logic signed [D-1:0]    hold_ref = '0;
  logic                   prev_rst = 1'b0;
  int                     mon_d;
  bit                     mon_s;

  always #5 clk = ~clk;

  cfa_window_mac dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .shift      (shift),
    .win_in     (win),
    .coeff_in   (coeff_in),
    .coeff_load (coeff_load),
    .d_out      (d_out),
    .d_valid    (d_valid),
    .sat        (sat)
  );

  // Upstream shift buffer model: newest sample enters the top tap.
  always @(posedge clk) begin
    if (rst) win <= '0;
    else if (en && shift) win <= {D'(sample), win[N*D-1:D]};
  end

  // Monitor: reset state, scoreboard pops on d_valid, hold checks in bubbles.
  always @(negedge clk) begin
    if (prev_rst) begin
      checks++;
      if (d_valid !== 1'b0 || d_out !== '0 || sat !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: d_valid=%b d_out=%0d sat=%b, required 0 0 0",
                 d_valid, d_out, sat);
      end
      hold_ref = '0;
    end else if (d_valid === 1'b1) begin
      checks++;
      if (exp_d.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: d_out=%0d sat=%b, required no d_valid", d_out, sat);
      end else begin
        mon_d = exp_d.pop_front();
        mon_s = exp_s.pop_front();
        if (d_out !== D'(mon_d) || sat !== mon_s) begin
          errors++;
          $display("FAIL output: d_out=%0d sat=%b, required d_out=%0d sat=%b",
                   d_out, sat, mon_d, mon_s);
        end
      end
      hold_ref = d_out;
    end else begin
      checks++;
      if (d_valid !== 1'b0 || d_out !== hold_ref) begin
        errors++;
        $display("FAIL bubble_hold: d_valid=%b d_out=%0d, required 0 and %0d",
                 d_valid, d_out, hold_ref);
      end
    end
    prev_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    shift = 1'b0;
    coeff_load = 1'b0;
    repeat (n) tick();
  endtask

  // One shift event; optionally queue the expected output for this window.
  task automatic sh(input int s, input bit ev, input int d, input bit sa);
    sample = s;
    en = 1'b1;
    shift = 1'b1;
    if (ev) begin
      exp_d.push_back(d);
      exp_s.push_back(sa);
    end
    tick();
    en = 1'b0;
    shift = 1'b0;
  endtask

  task automatic load_all(input int c);
    for (int k = 0; k < int'(N); k++) coeff_in[k*C +: C] = C'(c);
    coeff_load = 1'b1;
    tick();
    coeff_load = 1'b0;
  endtask

  task automatic load_center(input int c);
    coeff_in = '0;
    coeff_in[(N/2)*C +: C] = C'(c);
    coeff_load = 1'b1;
    tick();
    coeff_load = 1'b0;
  endtask

  task automatic do_rst(input int n);
    rst = 1'b1;
    en = 1'b0;
    shift = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    coeff_load = 1'b0;
    exp_d.delete();
    exp_s.delete();
  endtask

  initial begin
    do_rst(2);

    // Pass-through warm-up: only the fifth shift produces output.
    sh(1, 0, 0, 0);
    sh(2, 0, 0, 0);
    sh(3, 0, 0, 0);
    sh(4, 0, 0, 0);
    sh(5, 1, 3, 0);
    sh(6, 1, 4, 0);
    sh(7, 1, 5, 0);
    // Load lands on the stage-1 capture edge of sample 7: old coefficients.
    load_all(64);
    sh(8, 1, 30, 0);
    load_all(127);
    idle(3);

    // Saturation high, then low, with a stall mid-stream.
    repeat (5) sh(2047, 1, 2047, 1);
    sh(-2048, 1, 2047, 1);
    sh(-2048, 1, 2047, 1);
    idle(2);
    sh(-2048, 1, -2048, 1);
    idle(1);
    sh(-2048, 1, -2048, 1);
    sh(-2048, 1, -2048, 1);
    load_all(64);
    sh(10, 1, -2048, 1);
    sh(10, 1, -2048, 1);
    sh(10, 1, -2048, 1);
    sh(10, 1, -2008, 0);
    sh(10, 1, 50, 0);
    load_center(32);
    idle(3);

    // Rounding on the centre tap at 0.5.
    sh(3, 1, 5, 0);
    sh(3, 1, 5, 0);
    sh(3, 1, RndPos, 0);
    sh(-3, 1, RndPos, 0);
    sh(-3, 1, RndPos, 0);
    sh(-3, 1, RndNeg, 0);
    idle(4);

    // Reset with windows in flight and a simultaneous coefficient load.
    sh(100, 0, 0, 0);
    sh(200, 0, 0, 0);
    for (int k = 0; k < int'(N); k++) coeff_in[k*C +: C] = C'(127);
    coeff_load = 1'b1;
    do_rst(1);

    // Qualifier gating must not advance the fill count.
    sample = 99;
    en = 1'b1; shift = 1'b0;
    repeat (3) tick();
    en = 1'b0; shift = 1'b1;
    repeat (3) tick();
    shift = 1'b0;
    sh(1, 0, 0, 0);
    sh(2, 0, 0, 0);
    sh(3, 0, 0, 0);
    sh(4, 0, 0, 0);
    sh(5, 1, 3, 0);
    idle(4);

    // Box filter over window 1..5 after a fresh reset, with stalls.
    do_rst(1);
    load_all(64);
    sh(1, 0, 0, 0);
    sh(2, 0, 0, 0);
    idle(1);
    sh(3, 0, 0, 0);
    idle(2);
    sh(4, 0, 0, 0);
    sh(5, 1, 15, 0);
    idle(6);

    checks++;
    if (exp_d.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs still pending, required 0", exp_d.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
